// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ALU ops plus iterative shift-add multiply.
// Optional ALU_OVF_EN adds ovf_flag for signed ADD/SUB overflow.
module alu_exec_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        alu_op,
  input  logic [ADDR_W-1:0] dest_in,
  input  logic [WIDTH-1:0]  operand_a,
  input  logic [WIDTH-1:0]  operand_b,
  output logic              wb_enable,
  output logic [ADDR_W-1:0] wb_dest,
  output logic [WIDTH-1:0]  wb_data,
  output logic              done,
  output logic              zero_flag,
`ifdef ALU_OVF_EN
  output logic              ovf_flag,
`endif
  output logic              busy
);

  localparam int SH_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_WB
  } state_e;

  state_e state_q, state_d;

  logic [3:0]         op_q;
  logic [ADDR_W-1:0]  dest_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SH_W-1:0]    cnt_q;

  logic              wb_en_q;
  logic [ADDR_W-1:0] wb_dest_q;
  logic [WIDTH-1:0]  wb_data_q;
  logic              done_q;
  logic              zero_q;

  logic             accept;
  logic             is_mul_in;
  logic             op_valid;
  logic             wr_c;
  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH:0]   mul_sum;

  assign issue_ready = (state_q != S_MUL);
  assign busy        = (state_q == S_MUL);
  assign accept      = issue_valid && issue_ready;
  assign is_mul_in   = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
  assign op_valid    = (op_q <= OP_MULHU);
  assign wr_c        = (state_q == S_WB) && op_valid
                       && (dest_q != '0);

  assign wb_enable = wb_en_q;
  assign wb_dest   = wb_dest_q;
  assign wb_data   = wb_data_q;
  assign done      = done_q;
  assign zero_flag = zero_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_WB: begin
        if (accept) state_d = is_mul_in ? S_MUL : S_WB;
        else        state_d = S_IDLE;
      end
      S_MUL: begin
        if (cnt_q == SH_W'(WIDTH - 1)) state_d = S_WB;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Low half holds the unconsumed multiplier bits; high half the partial sum.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    sh     = b_q[SH_W-1:0];
    sum_c  = a_q + b_q;
    diff_c = a_q - b_q;
    res_c  = '0;
    case (op_q)
      OP_ADD:   res_c = sum_c;
      OP_SUB:   res_c = diff_c;
      OP_AND:   res_c = a_q & b_q;
      OP_OR:    res_c = a_q | b_q;
      OP_XOR:   res_c = a_q ^ b_q;
      OP_SLL:   res_c = a_q << sh;
      OP_SRL:   res_c = a_q >> sh;
      OP_SRA:   res_c = $signed(a_q) >>> sh;
      OP_SLT:   res_c = {{(WIDTH-1){1'b0}},
                         $signed(a_q) < $signed(b_q)};
      OP_SLTU:  res_c = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_MUL:   res_c = acc_q[WIDTH-1:0];
      OP_MULHU: res_c = acc_q[2*WIDTH-1:WIDTH];
      default:  res_c = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf_c;
  logic ovf_q;

  always_comb begin
    ovf_c = 1'b0;
    if (op_q == OP_ADD)
      ovf_c = (a_q[WIDTH-1] == b_q[WIDTH-1])
           && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
    else if (op_q == OP_SUB)
      ovf_c = (a_q[WIDTH-1] != b_q[WIDTH-1])
           && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset)                 ovf_q <= 1'b0;
    else if (state_q == S_WB)  ovf_q <= ovf_c;
  end

  assign ovf_flag = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dest_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= alu_op;
        dest_q <= dest_in;
        a_q    <= operand_a;
        b_q    <= operand_b;
        acc_q  <= {{WIDTH{1'b0}}, operand_b};
        cnt_q  <= '0;
      end else if (state_q == S_MUL) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + SH_W'(1);
      end
      done_q  <= (state_q == S_WB);
      zero_q  <= (state_q == S_WB) && (res_c == '0);
      wb_en_q <= wr_c;
      if (wr_c) begin
        wb_dest_q <= dest_q;
        wb_data_q <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed table, hand sequences, random ops
// against an arithmetic reference model.
module tb_alu_exec_unit;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic          issue_ready;
  logic [3:0]    alu_op;
  logic [AW-1:0] dest_in;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          wb_enable;
  logic [AW-1:0] wb_dest;
  logic [W-1:0]  wb_data;
  logic          done;
  logic          zero_flag;
  logic          busy;
`ifdef ALU_OVF_EN
  logic          ovf_flag;
`endif

  alu_exec_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .alu_op(alu_op),
    .dest_in(dest_in),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .wb_enable(wb_enable),
    .wb_dest(wb_dest),
    .wb_data(wb_data),
    .done(done),
    .zero_flag(zero_flag),
`ifdef ALU_OVF_EN
    .ovf_flag(ovf_flag),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [W-1:0]  hold_data;
  logic [AW-1:0] hold_dest;

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] dest;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  exp;
  } vec_t;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] model(logic [3:0] op,
                                         logic [W-1:0] a,
                                         logic [W-1:0] b);
    logic [63:0] p;
    int          s;
    p = {32'd0, a} * {32'd0, b};
    s = int'(b % 32);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << s;
      4'd6:    return a >> s;
      4'd7:    return $signed(a) >>> s;
      4'd8:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd9:    return (a < b) ? 1 : 0;
      4'd10:   return p[31:0];
      4'd11:   return p[63:32];
      default: return 0;
    endcase
  endfunction

  function automatic logic ovf_model(logic [3:0] op,
                                     logic [W-1:0] a,
                                     logic [W-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd0)      r = sa + sb;
    else if (op == 4'd1) r = sa - sb;
    else                 return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(logic [3:0] op, logic [AW-1:0] dest,
                        logic [W-1:0] a, logic [W-1:0] b,
                        logic [W-1:0] r);
    bit en, mul;
    int k, busy_n;
    en  = (dest != 0) && (op < 12);
    mul = (op == 10) || (op == 11);
    chk("issue_ready_idle", issue_ready, 1);
    alu_op      = op;
    dest_in     = dest;
    operand_a   = a;
    operand_b   = b;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    alu_op      = 4'($urandom);
    dest_in     = AW'($urandom);
    operand_a   = $urandom;
    operand_b   = $urandom;
    chk("done_clear", done, 0);
    busy_n = 0;
    for (k = 1; k <= 40; k++) begin
      if (busy) busy_n++;
      chk("ready_vs_busy", issue_ready, !busy);
      tick();
      if (done) break;
    end
    chk("latency", k, mul ? 33 : 1);
    chk("busy_cycles", busy_n, mul ? 32 : 0);
    if (en) begin
      hold_data = r;
      hold_dest = dest;
    end
    chk("done", done, 1);
    chk("wb_enable", wb_enable, en);
    chk("wb_dest", wb_dest, hold_dest);
    chk("wb_data", wb_data, hold_data);
    if (en) chk("zero_flag", zero_flag, r == 0);
`ifdef ALU_OVF_EN
    chk("ovf_flag", ovf_flag, ovf_model(op, a, b));
`endif
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   n_done, n_wr;
    logic [3:0] rop;
    logic [W-1:0] ra, rb;

    tbl.push_back('{4'd0,  5'd3, 32'h00000005, 32'hFFFFFFFB, 32'h00000000});
    tbl.push_back('{4'd7,  5'd1, 32'h80000000, 32'h00000024, 32'hF8000000});
    tbl.push_back('{4'd8,  5'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
    tbl.push_back('{4'd9,  5'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    tbl.push_back('{4'd10, 5'd7, 32'h00010000, 32'h00010001, 32'h00010000});
    tbl.push_back('{4'd11, 5'd7, 32'h00010000, 32'h00010001, 32'h00000001});
    tbl.push_back('{4'd1,  5'd4, 32'h00000003, 32'h00000005, 32'hFFFFFFFE});
    tbl.push_back('{4'd2,  5'd8, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
    tbl.push_back('{4'd3,  5'd8, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0});
    tbl.push_back('{4'd4,  5'd8, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0});
    tbl.push_back('{4'd5,  5'd9, 32'h00000001, 32'h0000001F, 32'h80000000});
    tbl.push_back('{4'd6,  5'd9, 32'h80000000, 32'h0000003F, 32'h00000001});
    tbl.push_back('{4'd14, 5'd6, 32'h12345678, 32'h00000001, 32'h00000000});
    tbl.push_back('{4'd10, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
    tbl.push_back('{4'd11, 5'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    tbl.push_back('{4'd0,  5'd10, 32'h7FFFFFFF, 32'h00000001, 32'h80000000});
    tbl.push_back('{4'd1,  5'd11, 32'h80000000, 32'h00000001, 32'h7FFFFFFF});

    reset       = 1'b1;
    issue_valid = 1'b0;
    alu_op      = '0;
    dest_in     = '0;
    operand_a   = '0;
    operand_b   = '0;
    hold_data   = '0;
    hold_dest   = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_wb_enable", wb_enable, 0);
    chk("rst_done", done, 0);
    chk("rst_zero_flag", zero_flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_data", wb_data, 0);
`ifdef ALU_OVF_EN
    chk("rst_ovf_flag", ovf_flag, 0);
`endif

    foreach (tbl[i])
      run_op(tbl[i].op, tbl[i].dest, tbl[i].a, tbl[i].b, tbl[i].exp);

    // Reset five cycles into a multiply must drop the op entirely.
    alu_op      = 4'd10;
    dest_in     = 5'd12;
    operand_a   = 32'h00000003;
    operand_b   = 32'h00000007;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_wb_enable", wb_enable, 0);
    chk("mrst_done", done, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_issue_ready", issue_ready, 1);
    chk("mrst_wb_data", wb_data, 0);
    hold_data = '0;
    hold_dest = '0;
    n_done = 0;
    n_wr   = 0;
    repeat (40) begin
      tick();
      if (done) n_done++;
      if (wb_enable) n_wr++;
    end
    chk("mrst_no_done", n_done, 0);
    chk("mrst_no_write", n_wr, 0);

    // Back-to-back: ADD dest 0 then OR dest 2.
    alu_op      = 4'd0;
    dest_in     = 5'd0;
    operand_a   = 32'h1;
    operand_b   = 32'h2;
    issue_valid = 1'b1;
    tick();
    alu_op    = 4'd3;
    dest_in   = 5'd2;
    operand_a = 32'h000000F0;
    operand_b = 32'h0000000F;
    tick();
    issue_valid = 1'b0;
    chk("b2b1_done", done, 1);
    chk("b2b1_wb_enable", wb_enable, 0);
    chk("b2b1_wb_data", wb_data, hold_data);
    tick();
    chk("b2b2_done", done, 1);
    chk("b2b2_wb_enable", wb_enable, 1);
    chk("b2b2_wb_dest", wb_dest, 2);
    chk("b2b2_wb_data", wb_data, 32'h000000FF);
    tick();
    chk("b2b_done_drop", done, 0);

    // Back-to-back: ADD dest 4 then reserved opcode 13.
    alu_op      = 4'd0;
    dest_in     = 5'd4;
    operand_a   = 32'h10;
    operand_b   = 32'h20;
    issue_valid = 1'b1;
    tick();
    alu_op    = 4'd13;
    dest_in   = 5'd5;
    operand_a = 32'hDEADBEEF;
    operand_b = 32'h1;
    tick();
    issue_valid = 1'b0;
    chk("rsv1_done", done, 1);
    chk("rsv1_wb_enable", wb_enable, 1);
    chk("rsv1_wb_data", wb_data, 32'h30);
    tick();
    chk("rsv2_done", done, 1);
    chk("rsv2_wb_enable", wb_enable, 0);
    chk("rsv2_wb_dest", wb_dest, 4);
    chk("rsv2_wb_data", wb_data, 32'h30);
    hold_data = 32'h30;
    hold_dest = 5'd4;
    tick();

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 7 == 0) ra = 32'h80000000;
      if (i % 11 == 0) rb = ra;
      run_op(rop, AW'($urandom), ra, rb, model(rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
